// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed seven-segment display controller. A binary value is loaded
//   through a load handshake, converted to BCD by a sequential double-dabble
//   engine (one shift per clock), then scanned across DIGITS common-select
//   digits at a rate set by an internal prescaler.
//
//   Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading-zero digits).
//
// Parameters
//   DATA_W   : width of the binary input value (>= 4)
//   DIGITS   : number of physical digits scanned (2..8)
//   SCAN_DIV : clk_i cycles each digit is held (>= 2)
// Ports
//   clk_i       : system clock
//   reset_n     : asynchronous active-low reset
//   value_i     : unsigned binary value to display
//   load_i      : load request, accepted only while busy_o is low
//   busy_o      : conversion in progress
//   overflow_o  : displayed value does not fit in DIGITS decimal digits
//   digit_en_o  : one-hot active-high digit select, bit 0 = least significant
//   segs_o      : active-high segments, bit6..bit0 = a..g
module seg_scan_display #(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4160
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] value_i,
    input  logic              load_i,
    output logic              busy_o,
    output logic              overflow_o,
    output logic [DIGITS-1:0] digit_en_o,
    output logic [6:0]        segs_o
);

    // ceil(DATA_W * log10(2)) + 1 nibbles, never fewer than the displayed digits
    localparam int NB_CALC = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int NBCD    = (NB_CALC > DIGITS) ? NB_CALC : DIGITS;
    localparam int CW      = $clog2(DATA_W);
    localparam int IW      = $clog2(DIGITS);
    localparam int PW      = $clog2(SCAN_DIV);

    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b1111110;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [NBCD-1:0][3:0]    bcd_q, bcd_adj, bcd_d;
    logic [DIGITS-1:0][3:0]  disp_q;
    logic                    ovf_q, hi_nz;
    logic [PW-1:0]           presc_q;
    logic [IW-1:0]           idx_q;
    logic [DIGITS-1:0]       digit_en_q, digit_en_d;
    logic [6:0]              segs_q, segs_d;
    logic [3:0]              cur_nib;
    logic                    blank;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 7'b1111110;
            4'd1:    dec7 = 7'b0110000;
            4'd2:    dec7 = 7'b1101101;
            4'd3:    dec7 = 7'b1111001;
            4'd4:    dec7 = 7'b0110011;
            4'd5:    dec7 = 7'b1011011;
            4'd6:    dec7 = 7'b1011111;
            4'd7:    dec7 = 7'b1110000;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1111011;
            default: dec7 = SEG_BLANK;
        endcase
    endfunction

    // Double-dabble step: add-3 correction, then shift {BCD, binary} left.
    always_comb begin
        for (int i = 0; i < NBCD; i++)
            bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end

    assign {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;

    generate
        if (NBCD > DIGITS) begin : g_hi
            assign hi_nz = |bcd_d[NBCD-1:DIGITS];
        end else begin : g_no_hi
            assign hi_nz = 1'b0;
        end
    endgenerate

    // Converter FSM; display register and overflow commit on the last shift.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_i) begin
                        bin_q   <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        state_q <= S_IDLE;
                        disp_q  <= bcd_d[DIGITS-1:0];
                        ovf_q   <= hi_nz;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        cur_nib    = '0;
        blank      = 1'b0;
        digit_en_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_en_d[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) cur_nib = disp_q[i];
        end
`ifdef LEAD_ZERO_BLANK_EN
        // Walk down from the top digit; a digit blanks only if it and every
        // digit above it are zero. Digit 0 is excluded so "0" stays visible.
        begin
            logic run;
            run = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                run = run & (disp_q[i] == 4'd0);
                if (idx_q == IW'(i)) blank = run;
            end
        end
`endif
        if (ovf_q)      segs_d = SEG_DASH;
        else if (blank) segs_d = SEG_BLANK;
        else            segs_d = dec7(cur_nib);
    end

    // Free-running scan; select and segments are registered together so
    // they always describe the same digit.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            digit_en_q <= DIGITS'(1);
            segs_q     <= SEG_ZERO;
        end else begin
            if (presc_q == PW'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            digit_en_q <= digit_en_d;
            segs_q     <= segs_d;
        end
    end

    assign busy_o     = (state_q == S_SHIFT);
    assign overflow_o = ovf_q;
    assign digit_en_o = digit_en_q;
    assign segs_o     = segs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
  localparam int S = 4;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] ZL = 7'b0000000;
`else
  localparam logic [6:0] ZL = 7'b1111110;
`endif
  localparam logic [6:0] DSH = 7'b0000001;

  logic       clk = 0, reset_n = 0, load_i = 0;
  logic [7:0] value_i = '0;
  logic       busy3, ovf3, busy2, ovf2;
  logic [2:0] en3;
  logic [1:0] en2;
  logic [6:0] seg3, seg2;
  int checks = 0, errors = 0;
  int cyc;

  seg_scan_display #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(S)) u3 (
    .clk_i(clk), .reset_n(reset_n), .value_i(value_i), .load_i(load_i),
    .busy_o(busy3), .overflow_o(ovf3), .digit_en_o(en3), .segs_o(seg3));
  seg_scan_display #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(S)) u2 (
    .clk_i(clk), .reset_n(reset_n), .value_i(value_i), .load_i(load_i),
    .busy_o(busy2), .overflow_o(ovf2), .digit_en_o(en2), .segs_o(seg2));

  always #5 clk = ~clk;

  // Edges seen since reset release; the scan position follows from it.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

  function automatic int exp_idx(int c, int d);
    return (c == 0) ? 0 : ((c - 1) / S) % d;
  endfunction

  function automatic logic [6:0] seg_of(int n);
    case (n)
      0: return 7'b1111110; 1: return 7'b0110000; 2: return 7'b1101101;
      3: return 7'b1111001; 4: return 7'b0110011; 5: return 7'b1011011;
      6: return 7'b1011111; 7: return 7'b1110000; 8: return 7'b1111111;
      9: return 7'b1111011; default: return 7'b0000000;
    endcase
  endfunction

  function automatic int pow10(int d);
    int p = 1;
    for (int k = 0; k < d; k++) p *= 10;
    return p;
  endfunction

  // Pattern digit d of a DIGITS=nd display should show for value v.
  function automatic logic [6:0] model(int v, int d, int nd);
    if (v > pow10(nd) - 1) return DSH;
`ifdef LEAD_ZERO_BLANK_EN
    if (d > 0 && v < pow10(d)) return 7'b0000000;
`endif
    return seg_of((v / pow10(d)) % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full DIGITS=3 scan period; also covers the DIGITS=2 instance.
  task automatic scan_check(input logic [2:0][6:0] e3, input logic [1:0][6:0] e2);
    int i3, i2;
    for (int k = 0; k < 3 * S; k++) begin
      i3 = exp_idx(cyc, 3);
      i2 = exp_idx(cyc, 2);
      chk("digit_en3", en3, 32'(1) << i3);
      chk("segs3", seg3, e3[i3]);
      chk("digit_en2", en2, 32'(1) << i2);
      chk("segs2", seg2, e2[i2]);
      @(negedge clk);
    end
  endtask

  task automatic do_load(input int v, input bit pulse, input logic [2:0][6:0] e3,
                         input logic [1:0][6:0] e2, input bit o3, input bit o2);
    int n = 0;
    value_i = 8'(v); load_i = 1;
    @(negedge clk);
    load_i = 0;
    while (busy3 && n < 50) begin
      n++;
      if (pulse && n == 3) begin value_i = 8'd200; load_i = 1; end
      else load_i = 0;
      @(negedge clk);
    end
    load_i = 0;
    chk("busy_len", n, 8);
    chk("busy2_fall", busy2, 0);
    chk("overflow3", ovf3, o3);
    chk("overflow2", ovf2, o2);
    @(negedge clk);
    chk("busy_idle", busy3, 0);
    scan_check(e3, e2);
  endtask

  task automatic model_load(input int v, input bit pulse);
    logic [2:0][6:0] e3;
    logic [1:0][6:0] e2;
    for (int d = 0; d < 3; d++) e3[d] = model(v, d, 3);
    for (int d = 0; d < 2; d++) e2[d] = model(v, d, 2);
    do_load(v, pulse, e3, e2, v > 999, v > 99);
  endtask

  typedef struct { int v; logic [2:0][6:0] s3; logic o2; } vec_t;
  vec_t tbl[4];

  initial begin
    int w;
    logic [1:0][6:0] e2;
    tbl[0] = '{255, {7'b1101101, 7'b1011011, 7'b1011011}, 1'b1};
    tbl[1] = '{100, {7'b0110000, 7'b1111110, 7'b1111110}, 1'b1};
    tbl[2] = '{123, {7'b0110000, 7'b1101101, 7'b1111001}, 1'b1};
    tbl[3] = '{250, {7'b1101101, 7'b1011011, 7'b1111110}, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy3, 0);
    chk("rst_ovf", ovf3, 0);
    chk("rst_en", en3, 3'b001);
    chk("rst_segs", seg3, 7'b1111110);
    reset_n = 1;
    scan_check({ZL, ZL, 7'b1111110}, {ZL, 7'b1111110});

    // Table vectors (all overflow the 2-digit instance)
    for (int i = 0; i < 4; i++) begin
      e2 = tbl[i].o2 ? {DSH, DSH} : {ZL, ZL};
      do_load(tbl[i].v, 1'b0, tbl[i].s3, e2, 1'b0, tbl[i].o2);
    end

    // Overflow clears on a fitting value
    do_load(42, 1'b0, {ZL, 7'b0110011, 7'b1101101}, {7'b0110011, 7'b1101101}, 1'b0, 1'b0);

    // Load during busy is dropped
    do_load(7, 1'b1, {ZL, ZL, 7'b1110000}, {ZL, 7'b1110000}, 1'b0, 1'b0);

    // Reset mid-conversion
    value_i = 8'd123; load_i = 1;
    @(negedge clk);
    load_i = 0;
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", busy3, 1);
    reset_n = 0;
    #1;
    chk("mid_busy", busy3, 0);
    chk("mid_ovf", ovf2, 0);
    chk("mid_en", en3, 3'b001);
    chk("mid_segs", seg3, 7'b1111110);
    chk("mid_en2", en2, 2'b01);
    @(negedge clk);
    reset_n = 1;
    scan_check({ZL, ZL, 7'b1111110}, {ZL, 7'b1111110});
    chk("post_rst_busy", busy3, 0);

    // Load accepted on the edge the scan index wraps
    w = 0;
    while (((cyc + 1) % (3 * S)) != 0 && w < 100) begin w++; @(negedge clk); end
    chk("wrap_align", (cyc + 1) % (3 * S), 0);
    model_load(9, 1'b0);

    // Randomized values against the model
    for (int i = 0; i < 20; i++) model_load($urandom_range(0, 255), 1'b0);
    model_load(0, 1'b0);
    model_load(99, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display controller. Accepts a binary value through a load handshake and converts it to BCD with a sequential double-dabble engine, one shift per clock. It then time-multiplexes DIGITS common-select digits at a rate set by an internal prescaler. It replaces the fixed divider, digit FSM, parser and decoder chain in the board top level with one self-contained block.

## Interface
- DATA_W, 8, width of binary input value (≥4)
- DIGITS, 4, number of physical digits scanned (2..8)
- SCAN_DIV, 4160, clk_i cycles each digit is held (≥2; 4160 at 2.08 MHz gives 2 ms/digit)
- clk_i  in  1  system clock (board oscillator)
- reset_n  in  1  asynchronous, active-low reset; assertion clears all state immediately, release synchronous to clk_i
- value_i  in  DATA_W  unsigned binary value to display
- load_i  in  1  load request; sampled on rising clk_i
- busy_o  out  1  conversion in progress; loads ignored while high
- overflow_o  out  1  displayed value exceeds 10^DIGITS−1
- digit_en_o  out  DIGITS  one-hot, active-high digit select; bit 0 = least significant digit
- segs_o  out  7  active-high segments, bit6..bit0 = a..g

## Operation
- Reset values: busy_o=0, overflow_o=0, digit_en_o=1 (digit 0), segs_o=7'b1111110 ("0"), display register all zero, prescaler 0, scan index 0.
- Load: when load_i=1 and busy_o=0 at a rising edge, capture value_i, clear BCD accumulator, and set busy_o=1. When load_i=1 and busy_o=1, the request is dropped; there is no queueing.
- Converter states are IDLE and SHIFT. SHIFT lasts exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts the combined {BCD, binary} register left by one. After the last shift, return to IDLE.
- The BCD accumulator holds ceil(DATA_W·0.30103)+1 nibbles, so no intermediate result is ever truncated.
- Commit: on the edge leaving SHIFT, the low DIGITS nibbles are copied to the display register. On the same edge, overflow_o is set to 1 if any higher nibble is nonzero, or 0 otherwise. The display never shows partial results.
- Overflow: while overflow_o=1, every scanned digit shows a dash (segs 7'b0000001).
- Scan: the prescaler counts 0..SCAN_DIV−1. At terminal count it wraps to 0 and the scan index advances, wrapping from DIGITS−1 to 0. The scan runs continuously and is independent of conversion.
- Decode: nibble 0..9 uses the standard a..g encoding. Nibbles 10..15 cannot occur; they must decode to blank (7'b0000000).
- Reset asserted mid-conversion aborts the conversion. All outputs return to reset values and the old display contents are lost.

## Timing
- Load to busy_o high: 1 cycle (registered).
- busy_o stays high for exactly DATA_W cycles. The display register and overflow_o update on the edge where busy_o falls. The first segs_o reflecting the new value appears 1 cycle later.
- A new load is accepted on the same edge busy_o is sampled 0, so the back-to-back load period is DATA_W+1 cycles.
- digit_en_o and segs_o are registered and change together, 1 cycle after the scan index advances. They never show mismatched digit/segment combinations.
- Full scan period: DIGITS·SCAN_DIV cycles.

## Configuration
- LEAD_ZERO_BLANK_EN defined: any digit above digit 0 is blanked (segs 7'b0000000, digit_en_o still asserted) when it and all more-significant digits are zero. Digit 0 is never blanked. Overflow dashes take precedence over blanking.
- Not defined: all digits always show their numeral, including leading zeros.

## Test plan
- DATA_W=8, DIGITS=3, SCAN_DIV=4: reset, hold load_i=0 -> digit_en_o=001, segs_o=1111110; digit_en_o cycles 001→010→100→001 every 4 cycles.
- Load 255 -> busy_o high for 8 cycles. Afterwards digits 0/1/2 show 5/5/2: 1011011, 1011011, 1101101. overflow_o=0.
- DIGITS=2, load 100 -> overflow_o=1 and both digits show 0000001. Then load 42 -> overflow_o=0 and digits show 2 and 4.
- Load 7, then pulse load_i with 200 at busy cycle 3 -> the second load is ignored and 7 is displayed. With LEAD_ZERO_BLANK_EN: digits 2,1 show 0000000 and digit 0 shows 1110000. Without the macro: 1111110, 1111110, 1110000.
- Load 123, then assert reset_n=0 on shift cycle 5 -> outputs immediately return to reset values. After release, display shows 0 and busy_o=0.
- Load 9 on the same edge the scan index wraps -> scan timing is unaffected and the new digits appear within one scan period after commit.
